demux32_scatter: RTL

//   Writer-side counterpart of mux32: routes one N-bit input word per handshake into one of
//   32 registered output channels, chosen by a 5-bit select.

---
 rtl/demux32_pkg.sv | 24 ++
 rtl/demux32_scatter_decoder.sv | 18 +
 rtl/demux32_scatter.sv | 107 ++++++++++
 3 files changed

// File: rtl/demux32_pkg.sv
// demux32 shared types and sizes.
// Exports the state enum, channel/select/length widths and the effective-length helper.
package demux32_pkg;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } demux32_state_t;

    localparam int CHANNELS = 32;
    localparam int SEL_W    = 5;
    localparam int LEN_W    = 6;

    // A length of 0 or anything past 32 means a full sweep.
    function automatic logic [LEN_W-1:0] eff_len(
        input logic [LEN_W-1:0] len
    );
        if (len == '0 || len > LEN_W'(CHANNELS)) begin
            return LEN_W'(CHANNELS);
        end
        return len;
    endfunction

endpackage

// File: rtl/demux32_scatter_decoder.sv
// decoder_5_to_32: one-hot write-enable decoder with enable.
// Ports: en (write strobe), addr (channel), onehot (per-channel enables).
module decoder_5_to_32
    import demux32_pkg::*;
(
    input  logic                en,
    input  logic [SEL_W-1:0]    addr,
    output logic [CHANNELS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/demux32_scatter.sv
// demux32_scatter: routes one word per handshake into 32 registered channels,
// with single writes and auto-incrementing bursts that wrap 31->0.
// Ports: clk, rst (sync, active-high); in_valid/in_ready handshake (in_ready = ~hold);
//   in_data, select, burst, burst_len (sampled in idle); hold; clear_updated;
//   outs[31:0][N-1:0] channel registers; updated sticky flags; busy (in burst).
// Option: DEMUX32_ZERO_REG_EN hardwires channel 0 (outs[0]=0, updated[0]=0).
module demux32_scatter
    import demux32_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N-1:0]                in_data,
    input  logic [SEL_W-1:0]            select,
    input  logic                        burst,
    input  logic [LEN_W-1:0]            burst_len,
    input  logic                        hold,
    input  logic [CHANNELS-1:0]         clear_updated,
    output logic [CHANNELS-1:0][N-1:0]  outs,
    output logic [CHANNELS-1:0]         updated,
    output logic                        busy
);

    demux32_state_t             state_q, state_d;
    logic [SEL_W-1:0]           ptr_q, ptr_d;
    logic [LEN_W-1:0]           rem_q, rem_d;
    logic [CHANNELS-1:0][N-1:0] outs_q, outs_d;
    logic [CHANNELS-1:0]        upd_q, upd_d;

    logic                       accept;
    logic [SEL_W-1:0]           waddr;
    logic [CHANNELS-1:0]        we;
    logic [LEN_W-1:0]           len_eff;

    assign in_ready = ~hold;
    assign accept   = in_valid & ~hold;
    assign waddr    = (state_q == S_BURST) ? ptr_q : select;
    assign len_eff  = eff_len(burst_len);

    decoder_5_to_32 u_dec (
        .en     (accept),
        .addr   (waddr),
        .onehot (we)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && burst && len_eff > LEN_W'(1)) begin
                    ptr_d   = select + SEL_W'(1);
                    rem_d   = len_eff - LEN_W'(1);
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (accept) begin
                    ptr_d = ptr_q + SEL_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            outs_d[k] = we[k] ? in_data : outs_q[k];
        end
        // Set wins over a same-cycle clear.
        upd_d = (upd_q & ~clear_updated) | we;
`ifdef DEMUX32_ZERO_REG_EN
        outs_d[0] = '0;
        upd_d[0]  = 1'b0;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            outs_q  <= '0;
            upd_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            outs_q  <= outs_d;
            upd_q   <= upd_d;
        end
    end

    assign outs    = outs_q;
    assign updated = upd_q;
    assign busy    = (state_q == S_BURST);

endmodule
